key_schedule: RTL and testbench
===============================

Name: key_schedule

Overview:
- AES-128 key expansion stage that sits directly upstream of the Round pipeline.
- Accepts one 128-bit cipher key and streams round keys 0..10 on the sub_key bus, one per cycle, each with a valid strobe.
- Keys are computed on the fly: one expansion step per cycle, using an internal 4-byte S-box and an Rcon counter.
- Downstream back-pressure can stall the stream.

Parameters:
- DATA_LEN, 128, key and round-key width; only 128 is supported.
- NUM_ROUNDS, 10, index of the last round key.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low.
- key_valid_in  input  1  key_in is valid this cycle.
- key_in  input  DATA_LEN  cipher key; byte 0 is at [127:120].
- key_ready  output  1  block is idle and can accept a key.
- sub_key_ready  input  1  downstream accepts the current sub_key.
- key_valid_out  output  1  sub_key and round_idx are valid.
- sub_key  output  DATA_LEN  current round key.
- round_idx  output  4  index of the current round key, 0..10.
- done  output  1  high while round key 10 is presented.

Behaviour:
- Reset (reset=0, asynchronous):
  - Go to IDLE.
  - key_ready=1, key_valid_out=0, sub_key=0, round_idx=0, done=0.
  - Internal key and Rcon registers clear.
- State IDLE:
  - key_ready=1, key_valid_out=0.
  - Accept when key_valid_in=1: latch key_in into the working register, go to EMIT.
- State EMIT:
  - key_ready=0; key_valid_in is ignored.
  - The cycle after acceptance presents round key 0 (equal to key_in) with key_valid_out=1 and round_idx=0.
- Advance rule:
  - A transfer occurs on a clock edge where key_valid_out=1 and sub_key_ready=1.
  - On a transfer with round_idx<10, the next cycle presents round key round_idx+1.
  - If sub_key_ready=0, sub_key, round_idx and key_valid_out hold unchanged and the schedule does not advance.
- Latency: with no stalls, round key i appears i+1 cycles after acceptance; round key 10 appears 11 cycles after acceptance.
- Expansion step:
  - Split the key into words w0=[127:96], w1, w2, w3=[31:0].
  - t = SubWord(RotWord(w3)) XOR {rcon,24'h0}.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - rcon sequence: 01,02,04,08,10,20,40,80,1b,36. Step to the next value by xtime (left shift, XOR 0x1b on carry-out).
  - rcon reloads to 01 on every key acceptance.
- Last key:
  - done=1 exactly while round_idx=10 and key_valid_out=1.
  - On transfer of round key 10, go to IDLE: key_valid_out=0, done=0, key_ready=1 next cycle.
  - sub_key keeps its last value but is not valid.
- Back-to-back keys: a new key can be accepted on the cycle after the return to IDLE. There is no overlap with an in-progress expansion.
- Simultaneous key_valid_in with the final transfer: ignored, because key_ready=0 that cycle. The source must hold key_valid_in until key_ready=1.
- Reset mid-operation: the stream aborts immediately, outputs take their reset values, and no partial round keys resume after reset.
- key_in changes while busy: no effect.
- The S-box is a combinational 256-entry ROM instantiated 4 times (FIPS-197 table). The only registered path is working key → next key, one step per cycle.

Test Plan:
- Reset with reset=0 for 2 cycles → key_ready=1, key_valid_out=0, sub_key=0, round_idx=0, done=0.
- Nominal FIPS-197 key:
  - Stimulus: key_in=2b7e151628aed2a6abf7158809cf4f3c, pulse key_valid_in, sub_key_ready=1.
  - Required sequence:
    - RK0 = 2b7e151628aed2a6abf7158809cf4f3c at +1 cycle.
    - RK1 = a0fafe1788542cb123a339392a6c7605 at +2.
    - RK2 = f2c295f27a96b9435935807a7359f67f at +3.
    - RK10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at +11, with done=1.
    - key_ready=1 at +12.
- Back-pressure: same key, drop sub_key_ready for 3 cycles while RK1 is presented → RK1 and round_idx=1 held stable for all 3 cycles, then RK2 follows. Total sequence unchanged, 11 valid transfers.
- Busy input: assert key_valid_in with key_in=0 during round_idx=5 → ignored; the stream still ends at d014f9a8c9ee2589e13f0cc8b6630ca6.
- Reset mid-stream: assert reset at round_idx=4 → outputs zero immediately. A new all-zero key afterwards gives RK1=62636363626363636263636362636363 and RK10=b4ef5bcb3e92e21123e951cf6f8f188e.
- Back-to-back keys: second key issued the cycle key_ready returns → its RK0 appears one cycle later, and its rcon restarts at 01 (verified by matching RK1).

Source files
------------

// File: rtl/key_schedule.sv
// AES-128 key expansion stage.
// Takes one cipher key and streams round keys 0..10, one per cycle with a
// valid strobe, honouring downstream back-pressure. Each round key is
// derived from the previous one by a single expansion step.

// FIPS-197 forward S-box as a combinational 256-entry ROM.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Byte for address 0 sits in the top eight bits of the table.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Address a is stored at bit offset (255 - a) * 8, i.e. {~a, 3'b000}.
    always_comb begin
        out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];
    end

endmodule

module key_schedule #(
    parameter int DATA_LEN   = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_valid_in,
    input  logic [DATA_LEN-1:0] key_in,
    output logic                key_ready,
    input  logic                sub_key_ready,
    output logic                key_valid_out,
    output logic [DATA_LEN-1:0] sub_key,
    output logic [3:0]          round_idx,
    output logic                done
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    state_t              state;
    state_t              state_next;
    logic [DATA_LEN-1:0] key_reg;
    logic [7:0]          rcon;

    logic                accept;
    logic                xfer;
    logic                last_key;

    logic [31:0]         w0, w1, w2, w3;
    logic [31:0]         rot_word;
    logic [31:0]         sub_word;
    logic [31:0]         temp;
    logic [31:0]         w0_n, w1_n, w2_n, w3_n;
    logic [DATA_LEN-1:0] next_key;
    logic [7:0]          rcon_next;

    assign accept   = (state == IDLE) && key_valid_in;
    assign xfer     = (state == EMIT) && sub_key_ready;
    assign last_key = (round_idx == LAST_IDX);

    // Expansion step: RotWord, SubWord through four S-box lookups, Rcon mix,
    // then the chained XOR across the four words.
    assign w0       = key_reg[127:96];
    assign w1       = key_reg[95:64];
    assign w2       = key_reg[63:32];
    assign w3       = key_reg[31:0];
    assign rot_word = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_word[8*i +: 8]),
            .out_byte (sub_word[8*i +: 8])
        );
    end

    assign temp     = sub_word ^ {rcon, 24'h0};
    assign w0_n     = w0 ^ temp;
    assign w1_n     = w1 ^ w0_n;
    assign w2_n     = w2 ^ w1_n;
    assign w3_n     = w3 ^ w2_n;
    assign next_key = {w0_n, w1_n, w2_n, w3_n};

    // Rcon advances by xtime: multiply by x in GF(2^8).
    assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept a key in IDLE, return after round key 10 moves.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned, which
        // would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (accept)           state_next = EMIT;
            EMIT:    if (xfer && last_key) state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // Output decode from the current state and round index.
    always_comb begin
        key_ready     = 1'b0;
        key_valid_out = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: key_ready = 1'b1;
            EMIT: begin
                key_valid_out = 1'b1;
                done          = last_key;
            end
            default: key_ready = 1'b1;
        endcase
    end

    // Working key, Rcon and round index: load on accept, step on each
    // transfer before the last; everything holds while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the working registers are ordinary flops, not a memory,
            // so clearing them here is cheap and guarantees a reset mid-stream
            // leaves nothing to resume from.
            key_reg   <= '0;
            rcon      <= 8'h00;
            round_idx <= 4'd0;
        end else if (accept) begin
            key_reg   <= key_in;
            rcon      <= 8'h01;
            round_idx <= 4'd0;
        end else if (xfer && !last_key) begin
            key_reg   <= next_key;
            rcon      <= rcon_next;
            round_idx <= round_idx + 4'd1;
        end
    end

    assign sub_key = key_reg;

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule: reset values, the FIPS-197 example key,
// back-pressure, busy-input rejection, mid-stream reset, back-to-back keys.
module tb_key_schedule;

    localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] F_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] F_RK2   = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] F_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk;
    logic         reset;
    logic         key_valid_in;
    logic [127:0] key_in;
    logic         key_ready;
    logic         sub_key_ready;
    logic         key_valid_out;
    logic [127:0] sub_key;
    logic [3:0]   round_idx;
    logic         done;

    int checks;
    int failures;
    int transfers;

    key_schedule #(
        .DATA_LEN   (128),
        .NUM_ROUNDS (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_valid_in  (key_valid_in),
        .key_in        (key_in),
        .key_ready     (key_ready),
        .sub_key_ready (sub_key_ready),
        .key_valid_out (key_valid_out),
        .sub_key       (sub_key),
        .round_idx     (round_idx),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: count a transfer if one happens on this edge, then settle.
    task automatic tick();
        if (key_valid_out === 1'b1 && sub_key_ready === 1'b1) transfers++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic rdy,
                               input logic vld, input logic dn);
        check({tag, "_ready"}, 128'(key_ready),     128'(rdy));
        check({tag, "_valid"}, 128'(key_valid_out), 128'(vld));
        check({tag, "_done"},  128'(done),          128'(dn));
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        transfers     = 0;
        reset         = 1'b0;
        key_valid_in  = 1'b0;
        key_in        = '0;
        sub_key_ready = 1'b1;

        // Reset held for two cycles.
        tick();
        tick();
        check_flags("rst", 1'b1, 1'b0, 1'b0);
        check("rst_sub_key", sub_key, 128'h0);
        check("rst_round_idx", 128'(round_idx), 128'd0);
        reset = 1'b1;
        tick();
        check_flags("idle", 1'b1, 1'b0, 1'b0);

        // Nominal FIPS-197 key, no stalls.
        key_in       = K_FIPS;
        key_valid_in = 1'b1;
        tick();
        key_valid_in = 1'b0;
        check("nom_rk0", sub_key, K_FIPS);
        check("nom_idx0", 128'(round_idx), 128'd0);
        check_flags("nom_rk0", 1'b0, 1'b1, 1'b0);
        tick();
        check("nom_rk1", sub_key, F_RK1);
        check("nom_idx1", 128'(round_idx), 128'd1);
        tick();
        check("nom_rk2", sub_key, F_RK2);
        for (int i = 3; i <= 9; i++) begin
            tick();
            check("nom_idx", 128'(round_idx), 128'(i));
            check("nom_mid_done", 128'(done), 128'd0);
        end
        tick();
        check("nom_rk10", sub_key, F_RK10);
        check("nom_idx10", 128'(round_idx), 128'd10);
        check_flags("nom_rk10", 1'b0, 1'b1, 1'b1);
        tick();
        check_flags("nom_end", 1'b1, 1'b0, 1'b0);
        check("nom_end_hold", sub_key, F_RK10);
        check("nom_transfers", 128'(transfers), 128'd11);

        // Back-to-back: issue the same key the cycle key_ready returns;
        // this stream also exercises back-pressure and a busy key_valid_in.
        transfers    = 0;
        key_in       = K_FIPS;
        key_valid_in = 1'b1;
        tick();
        key_valid_in = 1'b0;
        check("b2b_rk0", sub_key, K_FIPS);
        tick();
        check("b2b_rk1", sub_key, F_RK1);
        sub_key_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_key", sub_key, F_RK1);
            check("bp_hold_idx", 128'(round_idx), 128'd1);
            check("bp_hold_valid", 128'(key_valid_out), 128'd1);
        end
        sub_key_ready = 1'b1;
        tick();
        check("bp_rk2", sub_key, F_RK2);
        tick();
        tick();
        tick();
        check("busy_idx5", 128'(round_idx), 128'd5);
        key_in       = '0;
        key_valid_in = 1'b1;
        tick();
        key_valid_in = 1'b0;
        check("busy_idx6", 128'(round_idx), 128'd6);
        for (int i = 7; i <= 10; i++) tick();
        check("busy_rk10", sub_key, F_RK10);
        check("busy_done", 128'(done), 128'd1);
        tick();
        check_flags("busy_end", 1'b1, 1'b0, 1'b0);
        check("bp_transfers", 128'(transfers), 128'd11);

        // Reset mid-stream at round 4, then an all-zero key.
        key_in       = K_FIPS;
        key_valid_in = 1'b1;
        tick();
        key_valid_in = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        check("mid_idx4", 128'(round_idx), 128'd4);
        reset = 1'b0;
        #1;
        check_flags("mid_rst", 1'b1, 1'b0, 1'b0);
        check("mid_rst_key", sub_key, 128'h0);
        check("mid_rst_idx", 128'(round_idx), 128'd0);
        tick();
        reset = 1'b1;
        tick();
        check_flags("post_rst", 1'b1, 1'b0, 1'b0);
        key_in       = '0;
        key_valid_in = 1'b1;
        tick();
        key_valid_in = 1'b0;
        check("zero_rk0", sub_key, 128'h0);
        tick();
        check("zero_rk1", sub_key, Z_RK1);
        for (int i = 2; i <= 10; i++) tick();
        check("zero_rk10", sub_key, Z_RK10);
        check("zero_done", 128'(done), 128'd1);
        tick();
        check_flags("zero_end", 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
